// File: rtl/machine_control_pkg.sv
`default_nettype none
// ============================================================================
// Module  : machine_control_pkg
// Brief   : Shared encodings for the machine-mode trap controller: FSM
//           states, PC-source codes, mcause codes and SYSTEM decode fields.
//           The WFI_WAIT state exists only with MACHINE_CONTROL_WFI_EN.
// Revision: 1.0 - initial release
// ============================================================================
package machine_control_pkg;

    // Controller states; WFI_WAIT only exists when WFI support is built in
    typedef enum logic [2:0] {
        ST_RESET       = 3'd0,
        ST_OPERATING   = 3'd1,
        ST_TRAP_TAKEN  = 3'd2,
        ST_TRAP_RETURN = 3'd3
`ifdef MACHINE_CONTROL_WFI_EN
        ,ST_WFI_WAIT   = 3'd4
`endif
    } state_t;

    // PC-source select codes
    localparam logic [1:0] C_PC_SRC_BOOT = 2'b00;
    localparam logic [1:0] C_PC_SRC_EPC  = 2'b01;
    localparam logic [1:0] C_PC_SRC_TRAP = 2'b10;
    localparam logic [1:0] C_PC_SRC_NEXT = 2'b11;

    // mcause exception-code values (interrupts and exceptions share codes)
    localparam logic [3:0] C_CAUSE_MEI              = 4'd11;
    localparam logic [3:0] C_CAUSE_MSI              = 4'd3;
    localparam logic [3:0] C_CAUSE_MTI              = 4'd7;
    localparam logic [3:0] C_CAUSE_INSTR_MISALIGNED = 4'd0;
    localparam logic [3:0] C_CAUSE_ILLEGAL          = 4'd2;
    localparam logic [3:0] C_CAUSE_ECALL            = 4'd11;
    localparam logic [3:0] C_CAUSE_EBREAK           = 4'd3;
    localparam logic [3:0] C_CAUSE_LOAD_MISALIGNED  = 4'd4;
    localparam logic [3:0] C_CAUSE_STORE_MISALIGNED = 4'd6;

    // SYSTEM opcode and privileged-instruction discriminators
    localparam logic [4:0] C_SYS_OPC     = 5'b11100;
    localparam logic [6:0] C_FUNCT7_PRIV = 7'b0000000;
    localparam logic [6:0] C_FUNCT7_MRET = 7'b0011000;
    localparam logic [6:0] C_FUNCT7_WFI  = 7'b0001000;
    localparam logic [4:0] C_RS2_ECALL   = 5'd0;
    localparam logic [4:0] C_RS2_EBREAK  = 5'd1;
    localparam logic [4:0] C_RS2_MRET    = 5'd2;
    localparam logic [4:0] C_RS2_WFI     = 5'd5;

    // True when funct7/rs2 identify a given privileged SYSTEM instruction
    function automatic logic priv_match(input logic [6:0] f7,
                                        input logic [4:0] rs2,
                                        input logic [6:0] f7_ref,
                                        input logic [4:0] rs2_ref);
        return (f7 == f7_ref) && (rs2 == rs2_ref);
    endfunction

endpackage
`default_nettype wire

// File: rtl/machine_control_trap_priority_encoder.sv
`default_nettype none
// ============================================================================
// Module  : trap_priority_encoder
// Brief   : Combinational trap arbiter. Gates interrupts by global MIE and
//           picks the highest-priority interrupt or exception, returning
//           {valid, interrupt/exception flag, cause, misaligned flag}.
// Revision: 1.0 - initial release
// ============================================================================
module trap_priority_encoder
    import machine_control_pkg::*;
#(
    parameter int CAUSE_W = 4
) (
    input  logic               mie_i,
    input  logic               meie_i,
    input  logic               mtie_i,
    input  logic               msie_i,
    input  logic               meip_i,
    input  logic               mtip_i,
    input  logic               msip_i,
    input  logic               instr_misaligned_i,
    input  logic               illegal_i,
    input  logic               ecall_i,
    input  logic               ebreak_i,
    input  logic               load_misaligned_i,
    input  logic               store_misaligned_i,
    output logic               valid_o,
    output logic               i_or_e_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic               misaligned_o
);

    // Fixed-priority selection: interrupts first, so a coincident exception is dropped
    always_comb begin
        valid_o      = 1'b1;
        i_or_e_o     = 1'b0;
        cause_o      = '0;
        misaligned_o = 1'b0;
        if (mie_i && meip_i && meie_i) begin
            i_or_e_o = 1'b1;
            cause_o  = CAUSE_W'(C_CAUSE_MEI);
        end else if (mie_i && msip_i && msie_i) begin
            i_or_e_o = 1'b1;
            cause_o  = CAUSE_W'(C_CAUSE_MSI);
        end else if (mie_i && mtip_i && mtie_i) begin
            i_or_e_o = 1'b1;
            cause_o  = CAUSE_W'(C_CAUSE_MTI);
        end else if (instr_misaligned_i) begin
            cause_o      = CAUSE_W'(C_CAUSE_INSTR_MISALIGNED);
            misaligned_o = 1'b1;
        end else if (illegal_i) begin
            cause_o = CAUSE_W'(C_CAUSE_ILLEGAL);
        end else if (ecall_i) begin
            cause_o = CAUSE_W'(C_CAUSE_ECALL);
        end else if (ebreak_i) begin
            cause_o = CAUSE_W'(C_CAUSE_EBREAK);
        end else if (load_misaligned_i) begin
            cause_o      = CAUSE_W'(C_CAUSE_LOAD_MISALIGNED);
            misaligned_o = 1'b1;
        end else if (store_misaligned_i) begin
            cause_o      = CAUSE_W'(C_CAUSE_STORE_MISALIGNED);
            misaligned_o = 1'b1;
        end else begin
            valid_o = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/machine_control.sv
`default_nettype none
// ============================================================================
// Module  : machine_control
// Brief   : Machine-mode trap controller FSM. Detects exceptions, enabled
//           pending interrupts and MRET; drives PC source, flush, instret
//           and the mcause/mepc/mstatus update strobes.
//           Optional feature macro: MACHINE_CONTROL_WFI_EN (WFI stalls in
//           WFI_WAIT until an enabled interrupt is pending; otherwise WFI
//           retires as a NOP and stall_out is tied low).
// Revision: 1.0 - initial release
// ============================================================================
module machine_control
    import machine_control_pkg::*;
#(
    parameter int         CAUSE_W = 4,
    parameter logic [4:0] SYS_OPC = C_SYS_OPC
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [4:0]         opcode_6_to_2_in,
    input  logic [2:0]         funct3_in,
    input  logic [6:0]         funct7_in,
    input  logic [4:0]         rs1_addr_in,
    input  logic [4:0]         rs2_addr_in,
    input  logic [4:0]         rd_addr_in,
    input  logic               illegal_instr_in,
    input  logic               misaligned_instr_in,
    input  logic               misaligned_load_in,
    input  logic               misaligned_store_in,
    input  logic               mie_in,
    input  logic               meie_in,
    input  logic               mtie_in,
    input  logic               msie_in,
    input  logic               meip_in,
    input  logic               mtip_in,
    input  logic               msip_in,
    output logic [1:0]         pc_src_out,
    output logic               flush_out,
    output logic               trap_taken_out,
    output logic               set_cause_out,
    output logic               set_epc_out,
    output logic               i_or_e_out,
    output logic [CAUSE_W-1:0] cause_out,
    output logic               misaligned_exception_out,
    output logic               mie_clear_out,
    output logic               mie_set_out,
    output logic               instret_inc_out,
    output logic               stall_out
);

    state_t             state_q, state_d;
    logic [1:0]         pc_src_q;
    logic               flush_q, trap_taken_q, set_cause_q, set_epc_q;
    logic               mie_clear_q, mie_set_q;
    logic               i_or_e_q, misaligned_q;
    logic [CAUSE_W-1:0] cause_q;

    logic               w_sys_base, w_ecall, w_ebreak, w_mret;
    logic               w_trap_req, w_trap_ie, w_trap_mis;
    logic [CAUSE_W-1:0] w_trap_cause;

    // Privileged SYSTEM instructions all share funct3=0, rs1=0, rd=0
    assign w_sys_base = (opcode_6_to_2_in == SYS_OPC) && (funct3_in == 3'b000) &&
                        (rs1_addr_in == 5'd0) && (rd_addr_in == 5'd0);
    assign w_ecall    = w_sys_base && priv_match(funct7_in, rs2_addr_in, C_FUNCT7_PRIV, C_RS2_ECALL);
    assign w_ebreak   = w_sys_base && priv_match(funct7_in, rs2_addr_in, C_FUNCT7_PRIV, C_RS2_EBREAK);
    assign w_mret     = w_sys_base && priv_match(funct7_in, rs2_addr_in, C_FUNCT7_MRET, C_RS2_MRET);

`ifdef MACHINE_CONTROL_WFI_EN
    logic w_wfi, w_wake, stall_q;
    assign w_wfi  = w_sys_base && priv_match(funct7_in, rs2_addr_in, C_FUNCT7_WFI, C_RS2_WFI);
    // Wake-up ignores global MIE: a masked interrupt still ends the wait
    assign w_wake = (meip_in & meie_in) | (msip_in & msie_in) | (mtip_in & mtie_in);
    assign stall_out = stall_q;
`else
    assign stall_out = 1'b0;
`endif

    trap_priority_encoder #(
        .CAUSE_W            (CAUSE_W)
    ) u_trap_priority_encoder (
        .mie_i              (mie_in),
        .meie_i             (meie_in),
        .mtie_i             (mtie_in),
        .msie_i             (msie_in),
        .meip_i             (meip_in),
        .mtip_i             (mtip_in),
        .msip_i             (msip_in),
        .instr_misaligned_i (misaligned_instr_in),
        .illegal_i          (illegal_instr_in),
        .ecall_i            (w_ecall),
        .ebreak_i           (w_ebreak),
        .load_misaligned_i  (misaligned_load_in),
        .store_misaligned_i (misaligned_store_in),
        .valid_o            (w_trap_req),
        .i_or_e_o           (w_trap_ie),
        .cause_o            (w_trap_cause),
        .misaligned_o       (w_trap_mis)
    );

    // Next-state selection; TRAP_TAKEN and TRAP_RETURN last exactly one cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RESET:       state_d = ST_OPERATING;
            ST_OPERATING: begin
                if (w_trap_req)
                    state_d = ST_TRAP_TAKEN;
                else if (w_mret)
                    state_d = ST_TRAP_RETURN;
`ifdef MACHINE_CONTROL_WFI_EN
                else if (w_wfi)
                    state_d = ST_WFI_WAIT;
`endif
            end
            ST_TRAP_TAKEN:  state_d = ST_OPERATING;
            ST_TRAP_RETURN: state_d = ST_OPERATING;
`ifdef MACHINE_CONTROL_WFI_EN
            ST_WFI_WAIT:    if (w_wake) state_d = ST_OPERATING;
`endif
            default:        state_d = ST_RESET;
        endcase
    end

    // State register plus outputs registered from the state being entered
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= ST_RESET;
            pc_src_q     <= C_PC_SRC_BOOT;
            flush_q      <= 1'b1;
            trap_taken_q <= 1'b0;
            set_cause_q  <= 1'b0;
            set_epc_q    <= 1'b0;
            mie_clear_q  <= 1'b0;
            mie_set_q    <= 1'b0;
            cause_q      <= '0;
            i_or_e_q     <= 1'b0;
            misaligned_q <= 1'b0;
`ifdef MACHINE_CONTROL_WFI_EN
            stall_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pc_src_q     <= C_PC_SRC_NEXT;
            flush_q      <= 1'b0;
            trap_taken_q <= 1'b0;
            set_cause_q  <= 1'b0;
            set_epc_q    <= 1'b0;
            mie_clear_q  <= 1'b0;
            mie_set_q    <= 1'b0;
`ifdef MACHINE_CONTROL_WFI_EN
            stall_q      <= 1'b0;
`endif
            case (state_d)
                ST_RESET: begin
                    pc_src_q <= C_PC_SRC_BOOT;
                    flush_q  <= 1'b1;
                end
                ST_TRAP_TAKEN: begin
                    pc_src_q     <= C_PC_SRC_TRAP;
                    flush_q      <= 1'b1;
                    trap_taken_q <= 1'b1;
                    set_cause_q  <= 1'b1;
                    set_epc_q    <= 1'b1;
                    mie_clear_q  <= 1'b1;
                end
                ST_TRAP_RETURN: begin
                    pc_src_q  <= C_PC_SRC_EPC;
                    flush_q   <= 1'b1;
                    mie_set_q <= 1'b1;
                end
`ifdef MACHINE_CONTROL_WFI_EN
                ST_WFI_WAIT: stall_q <= 1'b1;
`endif
                default: ;
            endcase
            // Cause fields are captured only when a trap is accepted and then held
            if (state_q == ST_OPERATING && state_d == ST_TRAP_TAKEN) begin
                cause_q      <= w_trap_cause;
                i_or_e_q     <= w_trap_ie;
                misaligned_q <= w_trap_mis;
            end
        end
    end

    // Retire qualifies the instruction currently in OPERATING, so it cannot wait a cycle
    assign instret_inc_out = (state_q == ST_OPERATING) && !w_trap_req && !w_mret;

    assign pc_src_out               = pc_src_q;
    assign flush_out                = flush_q;
    assign trap_taken_out           = trap_taken_q;
    assign set_cause_out            = set_cause_q;
    assign set_epc_out              = set_epc_q;
    assign mie_clear_out            = mie_clear_q;
    assign mie_set_out              = mie_set_q;
    assign cause_out                = cause_q;
    assign i_or_e_out               = i_or_e_q;
    assign misaligned_exception_out = misaligned_q;

endmodule
`default_nettype wire

// File: tb/tb_machine_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_machine_control
// Brief   : Self-checking bench for machine_control: reset, a table of
//           single-cycle trap/return/retire vectors, reset during a trap,
//           and the WFI sequence (MACHINE_CONTROL_WFI_EN) or WFI-as-NOP.
// Revision: 1.0 - initial release
// ============================================================================
module tb_machine_control;

    localparam logic [4:0] OPC_SYS = 5'b11100;
    localparam logic [4:0] OPC_OP  = 5'b01100;
    localparam logic [1:0] K_NONE  = 2'd0;
    localparam logic [1:0] K_TRAP  = 2'd1;
    localparam logic [1:0] K_RET   = 2'd2;

    // Strobe bundle {pc_src[1:0], flush, set_cause, set_epc, trap_taken, mie_clear, mie_set, stall}
    localparam logic [8:0] S_RESET = 9'b00_1000000;
    localparam logic [8:0] S_OPER  = 9'b11_0000000;
    localparam logic [8:0] S_TRAP  = 9'b10_1111100;
    localparam logic [8:0] S_RET   = 9'b01_1000010;

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [4:0] opcode_6_to_2_in;
    logic [2:0] funct3_in;
    logic [6:0] funct7_in;
    logic [4:0] rs1_addr_in, rs2_addr_in, rd_addr_in;
    logic       illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in;
    logic       mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in;
    logic [1:0] pc_src_out;
    logic       flush_out, trap_taken_out, set_cause_out, set_epc_out, i_or_e_out;
    logic [3:0] cause_out;
    logic       misaligned_exception_out, mie_clear_out, mie_set_out, instret_inc_out, stall_out;

    always #5 clk_in = ~clk_in;

    machine_control dut (
        .clk_in                   (clk_in),
        .rst_in                   (rst_in),
        .opcode_6_to_2_in         (opcode_6_to_2_in),
        .funct3_in                (funct3_in),
        .funct7_in                (funct7_in),
        .rs1_addr_in              (rs1_addr_in),
        .rs2_addr_in              (rs2_addr_in),
        .rd_addr_in               (rd_addr_in),
        .illegal_instr_in         (illegal_instr_in),
        .misaligned_instr_in      (misaligned_instr_in),
        .misaligned_load_in       (misaligned_load_in),
        .misaligned_store_in      (misaligned_store_in),
        .mie_in                   (mie_in),
        .meie_in                  (meie_in),
        .mtie_in                  (mtie_in),
        .msie_in                  (msie_in),
        .meip_in                  (meip_in),
        .mtip_in                  (mtip_in),
        .msip_in                  (msip_in),
        .pc_src_out               (pc_src_out),
        .flush_out                (flush_out),
        .trap_taken_out           (trap_taken_out),
        .set_cause_out            (set_cause_out),
        .set_epc_out              (set_epc_out),
        .i_or_e_out               (i_or_e_out),
        .cause_out                (cause_out),
        .misaligned_exception_out (misaligned_exception_out),
        .mie_clear_out            (mie_clear_out),
        .mie_set_out              (mie_set_out),
        .instret_inc_out          (instret_inc_out),
        .stall_out                (stall_out)
    );

    // flags = {illegal, mis_instr, mis_load, mis_store, mie, meie, mtie, msie, meip, mtip, msip}
    typedef struct {
        logic [4:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [10:0] flags;
        logic [1:0]  kind;
        logic        instret;
        logic [3:0]  cause;
        logic        ie;
        logic        mis;
    } vec_t;

    typedef struct {
        int         idx;
        logic [8:0] strb;
        logic [3:0] cause;
        logic       ie;
        logic       mis;
    } exp_t;

    vec_t vecs[18];
    int   n_vec;
    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    function automatic logic [8:0] strobes();
        return {pc_src_out, flush_out, set_cause_out, set_epc_out, trap_taken_out,
                mie_clear_out, mie_set_out, stall_out};
    endfunction

    function automatic logic [8:0] kind_strobes(input logic [1:0] k);
        case (k)
            K_TRAP:  return S_TRAP;
            K_RET:   return S_RET;
            default: return S_OPER;
        endcase
    endfunction

    task automatic drive(input vec_t v);
        opcode_6_to_2_in = v.opc;
        funct3_in        = v.f3;
        funct7_in        = v.f7;
        rs1_addr_in      = v.rs1;
        rs2_addr_in      = v.rs2;
        rd_addr_in       = v.rd;
        {illegal_instr_in, misaligned_instr_in, misaligned_load_in, misaligned_store_in,
         mie_in, meie_in, mtie_in, msie_in, meip_in, mtip_in, msip_in} = v.flags;
    endtask

    task automatic idle();
        vec_t v;
        v = '{OPC_OP, 3'd0, 7'd0, 5'd2, 5'd3, 5'd1, 11'b0, K_NONE, 1'b1, 4'd0, 1'b0, 1'b0};
        drive(v);
    endtask

    // One vector: drive in OPERATING, check retire, then check the state entered
    task automatic run_vec(input int i);
        vec_t v;
        exp_t e;
        v = vecs[i];
        drive(v);
        @(negedge clk_in);
        chk($sformatf("v%0d operating", i), 32'(strobes()), 32'(S_OPER));
        chk($sformatf("v%0d instret", i), 32'(instret_inc_out), 32'(v.instret));
        e.idx   = i;
        e.strb  = kind_strobes(v.kind);
        e.cause = v.cause;
        e.ie    = v.ie;
        e.mis   = v.mis;
        sb.push_back(e);
        @(posedge clk_in); #1;
        idle();
        @(negedge clk_in);
        e = sb.pop_front();
        chk($sformatf("v%0d strobes", e.idx), 32'(strobes()), 32'(e.strb));
        chk($sformatf("v%0d cause", e.idx), 32'(cause_out), 32'(e.cause));
        chk($sformatf("v%0d i_or_e", e.idx), 32'(i_or_e_out), 32'(e.ie));
        chk($sformatf("v%0d misaligned", e.idx), 32'(misaligned_exception_out), 32'(e.mis));
        @(posedge clk_in); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            opc      f3    f7           rs1   rs2   rd    flags            kind    ret   cause  ie    mis
        vecs[0]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0000_0000_000, K_NONE, 1'b1, 4'd0,  1'b0, 1'b0};
        vecs[1]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0010_0000_000, K_TRAP, 1'b0, 4'd4,  1'b0, 1'b1};
        vecs[2]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b1000_1100_100, K_TRAP, 1'b0, 4'd11, 1'b1, 1'b0};
        vecs[3]  = '{OPC_SYS, 3'd0, 7'b0011000,  5'd0, 5'd2, 5'd0, 11'b0000_0000_000, K_RET,  1'b0, 4'd11, 1'b1, 1'b0};
        vecs[4]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0000_0010_010, K_NONE, 1'b1, 4'd11, 1'b1, 1'b0};
        vecs[5]  = '{OPC_SYS, 3'd0, 7'd0,        5'd0, 5'd0, 5'd0, 11'b0000_0000_000, K_TRAP, 1'b0, 4'd11, 1'b0, 1'b0};
        vecs[6]  = '{OPC_SYS, 3'd0, 7'd0,        5'd0, 5'd1, 5'd0, 11'b0000_0000_000, K_TRAP, 1'b0, 4'd3,  1'b0, 1'b0};
        vecs[7]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0101_0000_000, K_TRAP, 1'b0, 4'd0,  1'b0, 1'b1};
        vecs[8]  = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0001_0000_000, K_TRAP, 1'b0, 4'd6,  1'b0, 1'b1};
        vecs[9]  = '{OPC_SYS, 3'd0, 7'd0,        5'd0, 5'd0, 5'd0, 11'b1000_0000_000, K_TRAP, 1'b0, 4'd2,  1'b0, 1'b0};
        vecs[10] = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0000_1011_011, K_TRAP, 1'b0, 4'd3,  1'b1, 1'b0};
        vecs[11] = '{OPC_OP,  3'd0, 7'd0,        5'd2, 5'd3, 5'd1, 11'b0000_1010_110, K_TRAP, 1'b0, 4'd7,  1'b1, 1'b0};
        vecs[12] = '{OPC_SYS, 3'd0, 7'b0011000,  5'd0, 5'd2, 5'd1, 11'b0000_0000_000, K_NONE, 1'b1, 4'd7,  1'b1, 1'b0};
        vecs[13] = '{OPC_SYS, 3'd0, 7'd0,        5'd3, 5'd0, 5'd0, 11'b0000_0000_000, K_NONE, 1'b1, 4'd7,  1'b1, 1'b0};
        vecs[14] = '{OPC_SYS, 3'd0, 7'b0011000,  5'd0, 5'd2, 5'd0, 11'b0010_0000_000, K_TRAP, 1'b0, 4'd4,  1'b0, 1'b1};
        vecs[15] = '{OPC_SYS, 3'd1, 7'd0,        5'd0, 5'd1, 5'd0, 11'b0000_0000_000, K_NONE, 1'b1, 4'd4,  1'b0, 1'b1};
        vecs[16] = '{OPC_SYS, 3'd0, 7'b0011000,  5'd0, 5'd2, 5'd0, 11'b0000_1000_001, K_RET,  1'b0, 4'd4,  1'b0, 1'b1};
        vecs[17] = '{OPC_SYS, 3'd0, 7'b0001000,  5'd0, 5'd5, 5'd0, 11'b0000_0000_000, K_NONE, 1'b1, 4'd4,  1'b0, 1'b1};
`ifdef MACHINE_CONTROL_WFI_EN
        n_vec = 17;
`else
        n_vec = 18;
`endif

        // Reset held for two cycles
        idle();
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        chk("reset strobes", 32'(strobes()), 32'(S_RESET));
        chk("reset cause", 32'(cause_out), 32'd0);
        chk("reset i_or_e", 32'(i_or_e_out), 32'd0);
        chk("reset misaligned", 32'(misaligned_exception_out), 32'd0);
        chk("reset instret", 32'(instret_inc_out), 32'd0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("post-reset operating", 32'(strobes()), 32'(S_OPER));
        chk("post-reset instret", 32'(instret_inc_out), 32'd1);
        @(posedge clk_in); #1;

        for (int i = 0; i < n_vec; i++) run_vec(i);

`ifdef MACHINE_CONTROL_WFI_EN
        // WFI retires, then stalls until an enabled interrupt is pending
        idle();
        opcode_6_to_2_in = OPC_SYS; funct7_in = 7'b0001000;
        rs1_addr_in = 5'd0; rs2_addr_in = 5'd5; rd_addr_in = 5'd0; mie_in = 1'b1;
        @(negedge clk_in);
        chk("wfi instret", 32'(instret_inc_out), 32'd1);
        @(posedge clk_in); #1;
        idle();
        mie_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_in);
            chk($sformatf("wfi wait %0d strobes", k), 32'(strobes()), 32'(9'b11_0000001));
            chk($sformatf("wfi wait %0d instret", k), 32'(instret_inc_out), 32'd0);
            @(posedge clk_in); #1;
        end
        msip_in = 1'b1; msie_in = 1'b1;
        @(negedge clk_in);
        chk("wfi wake pending", 32'(stall_out), 32'd1);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("wfi woken operating", 32'(strobes()), 32'(S_OPER));
        chk("wfi woken instret", 32'(instret_inc_out), 32'd0);
        @(posedge clk_in); #1;
        idle();
        @(negedge clk_in);
        chk("wfi trap strobes", 32'(strobes()), 32'(S_TRAP));
        chk("wfi trap cause", 32'(cause_out), 32'd3);
        chk("wfi trap i_or_e", 32'(i_or_e_out), 32'd1);
        @(posedge clk_in); #1;
`endif

        // Reset arriving while in TRAP_TAKEN
        idle();
        misaligned_load_in = 1'b1;
        @(posedge clk_in); #1;
        idle();
        rst_in = 1'b1;
        @(negedge clk_in);
        chk("rst-in-trap taken", 32'(strobes()), 32'(S_TRAP));
        chk("rst-in-trap cause before", 32'(cause_out), 32'd4);
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("rst-in-trap strobes", 32'(strobes()), 32'(S_RESET));
        chk("rst-in-trap cause", 32'(cause_out), 32'd0);
        chk("rst-in-trap misaligned", 32'(misaligned_exception_out), 32'd0);
        rst_in = 1'b0;
        @(posedge clk_in); #1;
        @(negedge clk_in);
        chk("rst-in-trap recovered", 32'(strobes()), 32'(S_OPER));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
